// File: rtl/piho_x2_accum.sv
// piho_x2_accum: N-channel x^2 accumulator and sweep sequencer.
// Discards MCNdump thermalisation sweeps, squares and accumulates MCNconf
// sweeps per channel, then reduces the channel sums into x2sumall.
// Build option: PIHO_ACC_SAT_EN makes each per-channel add saturate at
// 2^ACCW-1 instead of wrapping.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start after reset
// ST_DUMP   | accepting and discarding thermalisation sweeps
// ST_ACCUM  | accepting beats, squaring and accumulating per channel
// ST_DRAIN  | one cycle for the final registered square to land
// ST_REDUCE | summing channel accumulators into x2sumall, one per cycle
// ST_DONE   | finish high, results held until next start
`timescale 1ns/1ps
module piho_x2_accum #(
    parameter int NCH  = 4,
    parameter int XW   = 32,
    parameter int ACCW = 64,
    parameter int SW   = ACCW + $clog2(NCH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       MCNconf,
    input  logic [31:0]       MCNdump,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [NCH*XW-1:0] s_x,
    input  logic              s_last,
    output logic [NCH*ACCW-1:0] x2sum,
    output logic [SW-1:0]     x2sumall,
    output logic [31:0]       looptimes,
    output logic              busy,
    output logic              finish
);

    localparam int PW = 2 * XW;
    localparam int IW = $clog2(NCH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMP,
        ST_ACCUM,
        ST_DRAIN,
        ST_REDUCE,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]     dump_left;
    logic [31:0]     conf_left;
    logic            beat;
    logic            sweep_end;
    logic            start_ok;

    logic signed [PW-1:0] xe   [NCH];
    logic [PW-1:0]        prod [NCH];
    logic [PW-1:0]        sq   [NCH];
    logic                 sq_vld;
    logic [ACCW-1:0]      acc     [NCH];
    logic [ACCW-1:0]      acc_nxt [NCH];

    logic [IW-1:0]   red_idx;
    logic [ACCW-1:0] red_sel;
    logic [ACCW-1:0] addend;
    logic            addend_vld;

    assign s_ready   = (state == ST_DUMP) || (state == ST_ACCUM);
    assign beat      = s_valid && s_ready;
    assign sweep_end = beat && s_last;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy      = (state == ST_DUMP) || (state == ST_ACCUM) ||
                       (state == ST_DRAIN) || (state == ST_REDUCE);
    assign finish    = (state == ST_DONE);

    // Per-channel square (x*x is never negative, so the product is taken
    // as unsigned) and accumulator next value.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign xe[g]   = PW'($signed(s_x[g*XW +: XW]));
        assign prod[g] = $unsigned(xe[g] * xe[g]);
        assign x2sum[g*ACCW +: ACCW] = acc[g];
`ifdef PIHO_ACC_SAT_EN
        logic [ACCW:0] sum_w;
        assign sum_w      = {1'b0, acc[g]} + (ACCW+1)'(sq[g]);
        assign acc_nxt[g] = sum_w[ACCW] ? {ACCW{1'b1}} : sum_w[ACCW-1:0];
`else
        assign acc_nxt[g] = acc[g] + ACCW'(sq[g]);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; sweep counters count down to a terminal value of 1.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    if (MCNdump != 32'd0)      state_nxt = ST_DUMP;
                    else if (MCNconf != 32'd0) state_nxt = ST_ACCUM;
                    else                       state_nxt = ST_DRAIN;
                end
            end
            ST_DUMP: begin
                if (sweep_end && (dump_left == 32'd1))
                    state_nxt = (conf_left != 32'd0) ? ST_ACCUM : ST_DRAIN;
            end
            ST_ACCUM: begin
                if (sweep_end && (conf_left == 32'd1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  state_nxt = ST_REDUCE;
            ST_REDUCE: begin
                if (red_idx == IW'(NCH)) state_nxt = ST_DONE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Sweep down-counters and looptimes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            looptimes <= '0;
            dump_left <= '0;
            conf_left <= '0;
        end else if (start_ok) begin
            looptimes <= '0;
            dump_left <= MCNdump;
            conf_left <= MCNconf;
        end else if (sweep_end) begin
            looptimes <= looptimes + 32'd1;
            if (state == ST_DUMP)  dump_left <= dump_left - 32'd1;
            if (state == ST_ACCUM) conf_left <= conf_left - 32'd1;
        end
    end

    // First pipeline stage: register squares of accepted ACCUM beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_vld <= 1'b0;
            for (int c = 0; c < NCH; c++) sq[c] <= '0;
        end else begin
            sq_vld <= beat && (state == ST_ACCUM);
            if (beat && (state == ST_ACCUM)) begin
                for (int c = 0; c < NCH; c++) sq[c] <= prod[c];
            end
        end
    end

    // Second pipeline stage: per-channel accumulate, cleared by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
        end else if (start_ok) begin
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
        end else if (sq_vld) begin
            for (int c = 0; c < NCH; c++) acc[c] <= acc_nxt[c];
        end
    end

    // Channel select for the reduction walk.
    always_comb begin
        red_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (red_idx == IW'(c)) red_sel = acc[c];
        end
    end

    // Reduction: the selected channel is registered, then added next cycle,
    // so the walk takes NCH+1 cycles and the mux stays out of the adder path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x2sumall   <= '0;
            red_idx    <= '0;
            addend     <= '0;
            addend_vld <= 1'b0;
        end else if (start_ok) begin
            x2sumall   <= '0;
            red_idx    <= '0;
            addend     <= '0;
            addend_vld <= 1'b0;
        end else if (state == ST_REDUCE) begin
            red_idx    <= red_idx + 1'b1;
            addend     <= red_sel;
            addend_vld <= (red_idx < IW'(NCH));
            if (addend_vld) x2sumall <= x2sumall + SW'(addend);
        end else begin
            red_idx    <= '0;
            addend_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piho_x2_accum.sv
// Directed testbench for piho_x2_accum (NCH=4, XW=32, ACCW=64).
`timescale 1ns/1ps
module tb_piho_x2_accum;

    localparam int NCH  = 4;
    localparam int XW   = 32;
    localparam int ACCW = 64;
    localparam int SW   = ACCW + $clog2(NCH) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [31:0]          MCNconf;
    logic [31:0]          MCNdump;
    logic                 s_valid;
    logic                 s_ready;
    logic [NCH*XW-1:0]    s_x;
    logic                 s_last;
    logic [NCH*ACCW-1:0]  x2sum;
    logic [SW-1:0]        x2sumall;
    logic [31:0]          looptimes;
    logic                 busy;
    logic                 finish;

    int checks   = 0;
    int failures = 0;

    piho_x2_accum #(.NCH(NCH), .XW(XW), .ACCW(ACCW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .MCNconf(MCNconf), .MCNdump(MCNdump),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_last(s_last),
        .x2sum(x2sum), .x2sumall(x2sumall), .looptimes(looptimes),
        .busy(busy), .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*XW-1:0] pack4(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                                 input logic [XW-1:0] c, input logic [XW-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic beat(input logic [NCH*XW-1:0] x, input logic last);
        int n;
        s_valid = 1'b1;
        s_x     = x;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        chk("beat_ready", {{(SW-1){1'b0}}, s_ready}, 1);
        tick();
    endtask

    task automatic run_start(input logic [31:0] dump_n, input logic [31:0] conf_n);
        MCNdump = dump_n;
        MCNconf = conf_n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_finish();
        int n;
        n = 0;
        while (!finish && n < 40) begin
            tick();
            n++;
        end
        chk("finish_wait", {{(SW-1){1'b0}}, finish}, 1);
    endtask

    initial begin
        logic [ACCW-1:0] ovf_exp;
        logic [ACCW-1:0] exp_main [NCH];
        exp_main[0] = 64'd6;
        exp_main[1] = 64'd24;
        exp_main[2] = 64'd54;
        exp_main[3] = 64'd96;

        rst_n = 1'b0; start = 1'b0; MCNconf = '0; MCNdump = '0;
        s_valid = 1'b0; s_x = '0; s_last = 1'b0;
        tick(); tick(); tick();
        chk("rst_x2sumall", x2sumall, 0);
        chk("rst_x2sum0", SW'(x2sum[0 +: ACCW]), 0);
        chk("rst_looptimes", SW'(looptimes), 0);
        chk("rst_finish", SW'(finish), 0);
        chk("rst_busy", SW'(busy), 0);
        chk("rst_ready", SW'(s_ready), 0);
        rst_n = 1'b1;
        tick();

        // Main run: 2 dump sweeps then 3 conf sweeps, 2 beats each.
        run_start(32'd2, 32'd3);
        chk("main_busy", SW'(busy), 1);
        chk("main_ready", SW'(s_ready), 1);
        for (int s = 0; s < 2; s++) begin
            beat(pack4(100, 100, 100, 100), 1'b0);
            beat(pack4(100, 100, 100, 100), 1'b1);
        end
        chk("dump_looptimes", SW'(looptimes), 2);
        chk("dump_discard", SW'(x2sum[3*ACCW +: ACCW]), 0);
        for (int s = 0; s < 3; s++) begin
            if (s == 2) start = 1'b1;
            beat(pack4(1, 2, 3, 4), 1'b0);
            start = 1'b0;
            beat(pack4(1, 2, 3, 4), 1'b1);
        end
        // Final beat accepted; hold s_valid high with junk data.
        s_x = pack4(7, 7, 7, 7);
        s_last = 1'b0;
        for (int k = 0; k < NCH + 2; k++) begin
            chk("tail_finish_low", SW'(finish), 0);
            chk("tail_ready_low", SW'(s_ready), 0);
            if (k == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("main_finish", SW'(finish), 1);
        chk("main_busy_done", SW'(busy), 0);
        chk("done_ready_low", SW'(s_ready), 0);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("main_x2sum%0d", c), SW'(x2sum[c*ACCW +: ACCW]), SW'(exp_main[c]));
        chk("main_x2sumall", x2sumall, 180);
        chk("main_looptimes", SW'(looptimes), 5);
        tick();
        chk("done_hold_all", x2sumall, 180);
        s_valid = 1'b0;

        // Start from DONE: negative samples.
        run_start(32'd0, 32'd1);
        chk("restart_clr_all", x2sumall, 0);
        chk("restart_clr_x2sum3", SW'(x2sum[3*ACCW +: ACCW]), 0);
        chk("restart_clr_loop", SW'(looptimes), 0);
        chk("restart_finish", SW'(finish), 0);
        chk("restart_busy", SW'(busy), 1);
        beat(pack4(-32'sd3, -32'sd3, -32'sd3, -32'sd3), 1'b1);
        s_valid = 1'b0;
        wait_finish();
        for (int c = 0; c < NCH; c++)
            chk($sformatf("neg_x2sum%0d", c), SW'(x2sum[c*ACCW +: ACCW]), 9);
        chk("neg_x2sumall", x2sumall, 36);
        chk("neg_looptimes", SW'(looptimes), 1);

        // Empty run: one dump sweep, no conf sweeps.
        run_start(32'd1, 32'd0);
        beat(pack4(55, 55, 55, 55), 1'b1);
        s_valid = 1'b0;
        wait_finish();
        chk("empty_x2sum0", SW'(x2sum[0 +: ACCW]), 0);
        chk("empty_x2sumall", x2sumall, 0);
        chk("empty_looptimes", SW'(looptimes), 1);

        // Overflow: 4 x (-2^31)^2 = 2^64 in channel 0.
`ifdef PIHO_ACC_SAT_EN
        ovf_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        ovf_exp = 64'h0;
`endif
        run_start(32'd0, 32'd1);
        for (int b = 0; b < 4; b++)
            beat(pack4(32'h8000_0000, 0, 0, 5), (b == 3));
        s_valid = 1'b0;
        wait_finish();
        chk("ovf_x2sum0", SW'(x2sum[0 +: ACCW]), SW'(ovf_exp));
        chk("ovf_x2sum3", SW'(x2sum[3*ACCW +: ACCW]), 100);
        chk("ovf_x2sumall", x2sumall, SW'(ovf_exp) + 100);

        // Reset in the middle of ACCUM.
        run_start(32'd0, 32'd3);
        beat(pack4(5, 5, 5, 5), 1'b1);
        beat(pack4(5, 5, 5, 5), 1'b1);
        beat(pack4(5, 5, 5, 5), 1'b0);
        chk("pre_rst_looptimes", SW'(looptimes), 2);
        chk("pre_rst_x2sum1", SW'(x2sum[1*ACCW +: ACCW]), 50);
        rst_n = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        s_valid = 1'b0;
        tick();
        chk("mrst_x2sum1", SW'(x2sum[1*ACCW +: ACCW]), 0);
        chk("mrst_x2sumall", x2sumall, 0);
        chk("mrst_looptimes", SW'(looptimes), 0);
        chk("mrst_finish", SW'(finish), 0);
        chk("mrst_busy", SW'(busy), 0);
        chk("mrst_ready", SW'(s_ready), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
